// File: rtl/riscv_pkg.sv
// Shared RV32 integer-pipeline constants and write-back result-select encodings.
// No logic: types, localparams and one helper only.
package riscv_pkg;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = $clog2(NREGS);

   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_MEM  = 2'b01,
      RES_PC4  = 2'b10,
      RES_RSVD = 2'b11
   } result_src_t;

   // A write-back select carries a committable value unless it is the reserved code.
   function automatic logic result_src_valid(input logic [1:0] src);
      return src != RES_RSVD;
   endfunction

endpackage

// File: rtl/wb_result_mux.sv
// Write-back result select (ALU / load / PC+4), combinational, zero latency, no flow control.
// valid drops for the reserved select so callers can suppress the commit.
module wb_result_mux
   import riscv_pkg::*;
#(
   parameter int W = XLEN
) (
   input  logic [1:0]   src,
   input  logic [W-1:0] alu_result,
   input  logic [W-1:0] read_data,
   input  logic [W-1:0] pc_plus4,
   output logic [W-1:0] result,
   output logic         valid
);

   always_comb begin
      result = '0;
      valid  = result_src_valid(src);
      case (src)
         RES_ALU:  result = alu_result;
         RES_MEM:  result = read_data;
         RES_PC4:  result = pc_plus4;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus 32-entry integer register file: commit on clk, async reads, commit counter.
// Reads see a commit next cycle, or same cycle when WB_REGFILE_BYPASS_EN is defined; no handshake.
module wb_regfile
   import riscv_pkg::*;
#(
   parameter  int XLEN_P = XLEN,
   parameter  int NREGS_P = NREGS,
   parameter  int CNT_W  = 32,
   localparam int AW_P   = $clog2(NREGS_P)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWriteW,
   input  logic [1:0]        ResultSrcW,
   input  logic [XLEN_P-1:0] ReadDataW,
   input  logic [XLEN_P-1:0] ALUResultW,
   input  logic [XLEN_P-1:0] PCPlus4W,
   input  logic [AW_P-1:0]   RdW,
   input  logic [AW_P-1:0]   A1,
   input  logic [AW_P-1:0]   A2,
   output logic [XLEN_P-1:0] RD1,
   output logic [XLEN_P-1:0] RD2,
   output logic [XLEN_P-1:0] ResultW,
   output logic [CNT_W-1:0]  wb_count
);

   logic [XLEN_P-1:0] regs [NREGS_P];
   logic              result_valid;
   logic              we;

   wb_result_mux #(.W(XLEN_P)) u_mux (
      .src        (ResultSrcW),
      .alu_result (ALUResultW),
      .read_data  (ReadDataW),
      .pc_plus4   (PCPlus4W),
      .result     (ResultW),
      .valid      (result_valid)
   );

   assign we = RegWriteW && (RdW != '0) && result_valid && !reset;

   // Entry 0 is cleared by reset and never written, so it always reads zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS_P; i++) regs[i] <= '0;
         wb_count <= '0;
      end else if (we) begin
         regs[RdW] <= ResultW;
         wb_count  <= wb_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_comb begin
      RD1 = regs[A1];
      RD2 = regs[A2];
`ifdef WB_REGFILE_BYPASS_EN
      if (we && (A1 == RdW)) RD1 = ResultW;
      if (we && (A2 == RdW)) RD2 = ResultW;
`endif
      if (A1 == '0) RD1 = '0;
      if (A2 == '0) RD2 = '0;
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed steps then random traffic against an array-based reference model.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWriteW;
   logic [1:0]  ResultSrcW;
   logic [31:0] ReadDataW, ALUResultW, PCPlus4W;
   logic [4:0]  RdW, A1, A2;
   logic [31:0] RD1, RD2, ResultW;
   logic [3:0]  wb_count;

   int total = 0;
   int bad   = 0;

   logic [31:0] model [32];
   int          model_cnt;

   always #5 clk = ~clk;

   wb_regfile #(.CNT_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .RegWriteW  (RegWriteW),
      .ResultSrcW (ResultSrcW),
      .ReadDataW  (ReadDataW),
      .ALUResultW (ALUResultW),
      .PCPlus4W   (PCPlus4W),
      .RdW        (RdW),
      .A1         (A1),
      .A2         (A2),
      .RD1        (RD1),
      .RD2        (RD2),
      .ResultW    (ResultW),
      .wb_count   (wb_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic rw, input logic [1:0] src, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                         input logic [4:0] a1, input logic [4:0] a2, input logic rst);
      RegWriteW = rw; ResultSrcW = src; RdW = rd;
      ALUResultW = alu; ReadDataW = mem; PCPlus4W = pc4;
      A1 = a1; A2 = a2; reset = rst;
   endtask

   function automatic logic [31:0] exp_result();
      case (ResultSrcW)
         2'd0:    return ALUResultW;
         2'd1:    return ReadDataW;
         2'd2:    return PCPlus4W;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic exp_we();
      return RegWriteW && (RdW != 0) && (ResultSrcW != 2'd3) && !reset;
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (a == 0) return 32'h0;
`ifdef WB_REGFILE_BYPASS_EN
      if (exp_we() && a == RdW) return exp_result();
`endif
      return model[a];
   endfunction

   task automatic check_comb(input string tag);
      #1;
      chk({tag, ".result"}, ResultW, exp_result());
      chk({tag, ".rd1"}, RD1, exp_read(A1));
      chk({tag, ".rd2"}, RD2, exp_read(A2));
      chk({tag, ".count"}, {28'h0, wb_count}, model_cnt);
   endtask

   // Advance one edge; the model applies the commit rules to the inputs held across it.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
         model_cnt = 0;
      end else if (exp_we()) begin
         model[RdW] = exp_result();
         model_cnt  = (model_cnt + 1) % 16;
      end
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = 32'hx;
      model_cnt = 0;

      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         A1 = 5'(i); A2 = 5'(31 - i);
         check_comb("rst_read");
      end
      chk("rst_count", {28'h0, wb_count}, 32'd0);

      set_in(1, 2'd0, 5'd5, 32'h1234_5678, 32'h0, 32'h0, 5'd5, 5'd0, 0);
      check_comb("wr_alu");
      tick();
      set_in(0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5, 0);
      #1;
      chk("x5", RD1, 32'h1234_5678);
      chk("cnt1", {28'h0, wb_count}, 32'd1);

      set_in(1, 2'd1, 5'd6, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd6, 5'd0, 0);
      check_comb("wr_mem");
      tick();
      set_in(0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd6, 5'd5, 0);
      #1;
      chk("x6", RD1, 32'hDEAD_BEEF);
      chk("cnt2", {28'h0, wb_count}, 32'd2);

      set_in(1, 2'd2, 5'd1, 32'h0, 32'h0, 32'h0000_0104, 5'd1, 5'd6, 0);
      check_comb("wr_pc4");
      tick();
      set_in(0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd6, 0);
      #1;
      chk("x1", RD1, 32'h0000_0104);
      chk("cnt3", {28'h0, wb_count}, 32'd3);

      set_in(1, 2'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0, 0);
      check_comb("wr_x0");
      tick();
      #1;
      chk("x0", RD1, 32'h0);
      chk("cnt_x0", {28'h0, wb_count}, 32'd3);

      set_in(1, 2'd3, 5'd7, 32'h7777_7777, 32'h8888_8888, 32'h9999_9999, 5'd7, 5'd7, 0);
      #1;
      chk("rsvd_result", ResultW, 32'h0);
      tick();
      set_in(0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd7, 5'd7, 0);
      #1;
      chk("x7", RD1, 32'h0);
      chk("cnt_rsvd", {28'h0, wb_count}, 32'd3);

      set_in(1, 2'd0, 5'd9, 32'h1111_1111, 32'h0, 32'h0, 5'd0, 5'd0, 0);
      tick();
      set_in(1, 2'd0, 5'd9, 32'hA5A5_A5A5, 32'h0, 32'h0, 5'd9, 5'd9, 0);
      #1;
`ifdef WB_REGFILE_BYPASS_EN
      chk("byp_rd1", RD1, 32'hA5A5_A5A5);
      chk("byp_rd2", RD2, 32'hA5A5_A5A5);
`else
      chk("old_rd1", RD1, 32'h1111_1111);
      chk("old_rd2", RD2, 32'h1111_1111);
`endif
      tick();
      set_in(0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd9, 0);
      #1;
      chk("new_rd1", RD1, 32'hA5A5_A5A5);
      chk("new_rd2", RD2, 32'hA5A5_A5A5);

      set_in(1, 2'd0, 5'd3, 32'h0000_0055, 32'h0, 32'h0, 5'd3, 5'd5, 1);
      tick();
      set_in(0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd5, 0);
      #1;
      chk("rst_x3", RD1, 32'h0);
      chk("rst_x5", RD2, 32'h0);
      chk("rst_wr_cnt", {28'h0, wb_count}, 32'd0);

      for (int n = 0; n < 400; n++) begin
         logic [4:0] rd;
         rd = 5'($urandom_range(0, 31));
         set_in(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), rd,
                $urandom, $urandom, $urandom,
                ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)),
                ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 49) == 0));
         check_comb("rand");
         tick();
      end

      for (int n = 0; n < 16 && model_cnt != 15; n++) begin
         set_in(1, 2'd0, 5'd12, $urandom, 32'h0, 32'h0, 5'd12, 5'd0, 0);
         tick();
      end
      chk("pre_wrap", {28'h0, wb_count}, 32'd15);
      set_in(1, 2'd2, 5'd13, 32'h0, 32'h0, 32'h0000_0200, 5'd13, 5'd0, 0);
      tick();
      set_in(0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd13, 5'd0, 0);
      #1;
      chk("wrap", {28'h0, wb_count}, 32'd0);
      chk("wrap_x13", RD1, 32'h0000_0200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
